cv32e40s_mpu_arbiter: RTL and testbench
=======================================

# cv32e40s_mpu_arbiter

Two-requester arbiter that shares one data-side MPU instance between the LSU and the XIF memory interface. It grants one requester at a time towards the MPU's core-side transaction port and holds the grant stable across back-pressure. A requester-ID FIFO returns in-order MPU responses to the requester that issued them, and the block generates the MPU's `core_one_txn_pend_n` and `core_mpu_err_wait_i` controls.

## Interface
- `REQ_W`, 72: width of the opaque request payload (address, we, be, wdata, attributes).
- `RESP_W`, 40: width of the opaque response payload (bus response plus MPU status).
- `DEPTH`, 2: maximum outstanding accepted transactions; power of two, 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `lsu_req_valid_i`  in  1  LSU request valid.
- `lsu_req_ready_o`  out  1  LSU request accepted.
- `lsu_req_i`  in  REQ_W  LSU request payload.
- `xif_req_valid_i`  in  1  XIF request valid.
- `xif_req_ready_o`  out  1  XIF request accepted.
- `xif_req_i`  in  REQ_W  XIF request payload.
- `mpu_trans_valid_o`  out  1  request towards the MPU.
- `mpu_trans_ready_i`  in  1  MPU ready.
- `mpu_trans_o`  out  REQ_W  muxed payload.
- `mpu_err_wait_o`  out  1  drives the MPU's `core_mpu_err_wait_i`; 1 when the LSU owns the grant.
- `mpu_err_i`  in  1  the MPU's immediate `core_mpu_err_o`.
- `mpu_one_txn_pend_n_o`  out  1  drives the MPU's `core_one_txn_pend_n`.
- `mpu_resp_valid_i`  in  1  MPU response valid.
- `mpu_resp_i`  in  RESP_W  MPU response.
- `lsu_resp_valid_o`, `xif_resp_valid_o`  out  1 each  routed response valid.
- `resp_o`  out  RESP_W  `mpu_resp_i` passed through.
- `outstanding_o`  out  $clog2(DEPTH+1)  current outstanding count.
- `resp_err_o`  out  1  sticky flag: a response arrived with no outstanding transaction.

## Operation
- **Grant selection.**
  - When `lock_q`=0, the arbiter picks among the valid requesters (see Configuration).
  - When `lock_q`=1, the grant is forced to `owner_q`.
- **Lock.**
  - `lock_q` sets when `mpu_trans_valid_o` is high and `mpu_trans_ready_i` is low; `owner_q` captures the current grant.
  - `lock_q` clears on acceptance.
  - Both rules guarantee that a valid request is never retracted or switched by the arbiter.
- **Full block.**
  - When `outstanding`==DEPTH, `mpu_trans_valid_o`=0 and both ready outputs are 0. There is no pop bypass.
  - Lock cannot be active while full, because valid is never raised when full.
- **Request path.**
  - `mpu_trans_valid_o` = granted requester's valid and not full.
  - `mpu_trans_o` = granted requester's payload.
  - Granted requester's ready = `mpu_trans_ready_i` and not full. The other requester's ready is 0.
- **Acceptance.** Acceptance (accept) = `mpu_trans_valid_o` and `mpu_trans_ready_i`.
- **ID push.**
  - On accept, the granted ID (0=LSU, 1=XIF) is pushed into the FIFO.
  - Exception: if XIF owns the grant and `mpu_err_i`=1, no push. With err-wait low the MPU consumes the transaction and produces no response.
- **Pop and routing.**
  - Pop happens on `mpu_resp_valid_i` when the FIFO is non-empty.
  - The head ID selects `lsu_resp_valid_o` or `xif_resp_valid_o`.
  - `resp_o` is always `mpu_resp_i`.
- **Empty response.** `mpu_resp_valid_i` with an empty FIFO drives both resp valids to 0 and sets `resp_err_o`. The flag is cleared only by `rst`.
- **Count.**
  - `cnt_n` = `cnt_q` + push − pop.
  - Simultaneous push and pop leave the count unchanged.
  - Overflow and underflow are impossible by construction.
- **Pend indication.** `mpu_one_txn_pend_n_o` = (`cnt_n` == 1). This is combinational from push/pop of the current cycle.

## Timing
- The request and response paths are combinational: zero added latency.
- FIFO, count, lock, owner and RR pointer update at the rising edge of `clk`.
- Reset values:
  - State: `cnt_q`=0, FIFO empty, `lock_q`=0, `owner_q`=LSU, RR pointer=LSU, `resp_err_o`=0.
  - Outputs with valid inputs low: all valids/readies 0, `mpu_one_txn_pend_n_o`=0, `mpu_err_wait_o`=1, `outstanding_o`=0.
- Mid-operation reset: `rst` asserted mid-operation immediately clears all state. Responses for pre-reset transactions after release are flagged via `resp_err_o`.
- A response may arrive in the same cycle as its request's acceptance only if the FIFO already holds that ID. A push is visible to pop from the next cycle.

## Configuration
- Macro: `CV32E40S_MPU_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - The RR pointer points at the preferred requester.
  - On each accept it moves to the requester that was not granted.
  - With a single valid requester, that requester wins regardless of the pointer.
- Undefined: fixed priority, LSU over XIF. The RR pointer is not implemented.

## Test plan
- **Basic LSU path.** DEPTH=2. LSU issues 2 back-to-back reads, MPU ready=1, with 2 responses 3 cycles later. Required:
  - `outstanding_o` goes 1,2,2,2,1,0.
  - Both responses appear on `lsu_resp_valid_o`.
  - `mpu_one_txn_pend_n_o`=1 in the cycles where `cnt_n`=1.
- **Grant lock under back-pressure.** XIF valid, ready=0 for 3 cycles, LSU raises valid in cycle 1. Required:
  - XIF is held granted until accepted, with `mpu_trans_o`=`xif_req_i` throughout.
  - LSU is granted in the next cycle.
- **XIF immediate error.** XIF accept with `mpu_err_i`=1. Required: no push, `outstanding_o` stays 0, no response routed.
- **Full plus simultaneous push/pop.** FIFO full, both valids high. Required:
  - Both readies are 0.
  - After a pop, the next cycle accepts one request, and the count returns to 2.
- **Empty response.** `mpu_resp_valid_i` with an empty FIFO. Required:
  - `resp_err_o`=1 and stays set.
  - `rst` pulse returns it to 0.
- **Arbitration policy.** Both requesters valid continuously for 4 accepts. Required:
  - With the macro defined: grants go LSU,XIF,LSU,XIF.
  - With the macro undefined: grants are LSU ×4.

Source files
------------

// File: rtl/cv32e40s_mpu_arbiter.sv
// Shares one data-side MPU between the LSU and XIF requesters, routing in-order responses back
// via a requester-ID FIFO. Define CV32E40S_MPU_ARB_RR_EN for round-robin; default is LSU-first priority.
module cv32e40s_mpu_arbiter #(
  parameter int unsigned REQ_W  = 72,
  parameter int unsigned RESP_W = 40,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lsu_req_valid_i,
  output logic                         lsu_req_ready_o,
  input  logic [REQ_W-1:0]             lsu_req_i,
  input  logic                         xif_req_valid_i,
  output logic                         xif_req_ready_o,
  input  logic [REQ_W-1:0]             xif_req_i,
  output logic                         mpu_trans_valid_o,
  input  logic                         mpu_trans_ready_i,
  output logic [REQ_W-1:0]             mpu_trans_o,
  output logic                         mpu_err_wait_o,
  input  logic                         mpu_err_i,
  output logic                         mpu_one_txn_pend_n_o,
  input  logic                         mpu_resp_valid_i,
  input  logic [RESP_W-1:0]            mpu_resp_i,
  output logic                         lsu_resp_valid_o,
  output logic                         xif_resp_valid_o,
  output logic [RESP_W-1:0]            resp_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         resp_err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic        ID_LSU = 1'b0;
  localparam logic        ID_XIF = 1'b1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic             lock_q, lock_d;
  logic             owner_q, owner_d;
  logic             resp_err_q, resp_err_d;
  logic             gnt, gnt_valid, full, empty, accept, push, pop, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

`ifdef CV32E40S_MPU_ARB_RR_EN
  logic rr_q, rr_d;

  // rr_q names the preferred requester when both are valid
  always_comb begin
    gnt = ID_LSU;
    if (lock_q) begin
      gnt = owner_q;
    end else if (lsu_req_valid_i && xif_req_valid_i) begin
      gnt = rr_q;
    end else if (xif_req_valid_i) begin
      gnt = ID_XIF;
    end
  end

  assign rr_d = accept ? ~gnt : rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= ID_LSU;
    else     rr_q <= rr_d;
  end
`else
  always_comb begin
    gnt = ID_LSU;
    if (lock_q) begin
      gnt = owner_q;
    end else if (!lsu_req_valid_i && xif_req_valid_i) begin
      gnt = ID_XIF;
    end
  end
`endif

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign gnt_valid = (gnt == ID_XIF) ? xif_req_valid_i : lsu_req_valid_i;

  assign mpu_trans_valid_o = gnt_valid & ~full;
  assign mpu_trans_o       = (gnt == ID_XIF) ? xif_req_i : lsu_req_i;
  assign lsu_req_ready_o   = (gnt == ID_LSU) & mpu_trans_ready_i & ~full;
  assign xif_req_ready_o   = (gnt == ID_XIF) & mpu_trans_ready_i & ~full;
  assign mpu_err_wait_o    = (gnt == ID_LSU);

  // An XIF transaction rejected immediately by the MPU never produces a response
  assign accept = mpu_trans_valid_o & mpu_trans_ready_i;
  assign push   = accept & ~((gnt == ID_XIF) & mpu_err_i);
  assign pop    = mpu_resp_valid_i & ~empty;
  assign head   = fifo_q[rd_ptr_q];

  assign lsu_resp_valid_o = pop & (head == ID_LSU);
  assign xif_resp_valid_o = pop & (head == ID_XIF);
  assign resp_o           = mpu_resp_i;

  assign cnt_d                = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign mpu_one_txn_pend_n_o = (cnt_d == CNT_W'(1));
  assign outstanding_o        = cnt_q;
  assign resp_err_o           = resp_err_q;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // Hold the grant while a presented request is stalled so it is never retracted or switched
  assign lock_d     = mpu_trans_valid_o & ~mpu_trans_ready_i;
  assign owner_d    = lock_d ? gnt : owner_q;
  assign resp_err_d = resp_err_q | (mpu_resp_valid_i & empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_q     <= '0;
      lock_q     <= 1'b0;
      owner_q    <= ID_LSU;
      resp_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_cv32e40s_mpu_arbiter.sv
// Directed bench: stimulus pushes expected response routing into a queue, a monitor pops and compares.
module tb_cv32e40s_mpu_arbiter;

  localparam int unsigned REQ_W  = 72;
  localparam int unsigned RESP_W = 40;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;
`ifdef CV32E40S_MPU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [REQ_W-1:0] L1 = 72'h11_0000_0000_0000_0001;
  localparam logic [REQ_W-1:0] L2 = 72'h11_0000_0000_0000_0002;
  localparam logic [REQ_W-1:0] L3 = 72'h11_0000_0000_0000_0003;
  localparam logic [REQ_W-1:0] X1 = 72'h22_0000_0000_0000_0001;
  localparam logic [REQ_W-1:0] X2 = 72'h22_0000_0000_0000_0002;
  localparam logic [REQ_W-1:0] Z  = '0;

  logic              clk, rst;
  logic              lsu_req_valid_i, lsu_req_ready_o, xif_req_valid_i, xif_req_ready_o;
  logic [REQ_W-1:0]  lsu_req_i, xif_req_i, mpu_trans_o;
  logic              mpu_trans_valid_o, mpu_trans_ready_i, mpu_err_wait_o, mpu_err_i;
  logic              mpu_one_txn_pend_n_o, mpu_resp_valid_i;
  logic [RESP_W-1:0] mpu_resp_i, resp_o;
  logic              lsu_resp_valid_o, xif_resp_valid_o, resp_err_o;
  logic [CNT_W-1:0]  outstanding_o;

  typedef struct packed {
    logic              id;
    logic [RESP_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  cv32e40s_mpu_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_req_i(lsu_req_i),
    .xif_req_valid_i(xif_req_valid_i), .xif_req_ready_o(xif_req_ready_o), .xif_req_i(xif_req_i),
    .mpu_trans_valid_o(mpu_trans_valid_o), .mpu_trans_ready_i(mpu_trans_ready_i),
    .mpu_trans_o(mpu_trans_o), .mpu_err_wait_o(mpu_err_wait_o), .mpu_err_i(mpu_err_i),
    .mpu_one_txn_pend_n_o(mpu_one_txn_pend_n_o), .mpu_resp_valid_i(mpu_resp_valid_i),
    .mpu_resp_i(mpu_resp_i), .lsu_resp_valid_o(lsu_resp_valid_o),
    .xif_resp_valid_o(xif_resp_valid_o), .resp_o(resp_o),
    .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkc(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge; checks follow 1 time unit later
  task automatic drv(input logic lv, input logic [REQ_W-1:0] lreq, input logic xv,
                     input logic [REQ_W-1:0] xreq, input logic rdy, input logic err,
                     input logic rv, input logic [RESP_W-1:0] rd);
    @(negedge clk);
    lsu_req_valid_i   = lv;
    lsu_req_i         = lreq;
    xif_req_valid_i   = xv;
    xif_req_i         = xreq;
    mpu_trans_ready_i = rdy;
    mpu_err_i         = err;
    mpu_resp_valid_i  = rv;
    mpu_resp_i        = rd;
    #1;
  endtask

  task automatic expect_resp(input logic id, input logic [RESP_W-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every routed response must match the oldest expected entry
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #4;
      if (lsu_resp_valid_o || xif_resp_valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_route: unexpected response lsu=%0b xif=%0b data=%0h",
                   lsu_resp_valid_o, xif_resp_valid_o, resp_o);
        end else begin
          e = exp_q.pop_front();
          if ({xif_resp_valid_o, lsu_resp_valid_o, resp_o} !== {e.id, ~e.id, e.data}) begin
            n_err++;
            $display("FAIL resp_route: got xif=%0b lsu=%0b data=%0h expected xif=%0b lsu=%0b data=%0h",
                     xif_resp_valid_o, lsu_resp_valid_o, resp_o, e.id, ~e.id, e.data);
          end
        end
      end
    end
  end

  logic [3:0] g6;
  logic       g4;

  initial begin
    rst = 1'b1;
    lsu_req_valid_i = 1'b0; lsu_req_i = '0; xif_req_valid_i = 1'b0; xif_req_i = '0;
    mpu_trans_ready_i = 1'b0; mpu_err_i = 1'b0; mpu_resp_valid_i = 1'b0; mpu_resp_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chk1("rst_trans_valid", mpu_trans_valid_o, 1'b0);
    chk1("rst_lsu_ready", lsu_req_ready_o, 1'b0);
    chk1("rst_xif_ready", xif_req_ready_o, 1'b0);
    chk1("rst_pend_n", mpu_one_txn_pend_n_o, 1'b0);
    chk1("rst_err_wait", mpu_err_wait_o, 1'b1);
    chkc("rst_outstanding", outstanding_o, 2'd0);
    chk1("rst_resp_err", resp_err_o, 1'b0);

    // Basic LSU path: two back-to-back reads, responses later
    drv(1, L1, 0, Z, 1, 0, 0, '0);
    chk1("t1_ready0", lsu_req_ready_o, 1'b1);
    chkw("t1_trans0", mpu_trans_o, L1);
    chk1("t1_pend0", mpu_one_txn_pend_n_o, 1'b1);
    chkc("t1_out0", outstanding_o, 2'd0);
    expect_resp(1'b0, 40'h00_0000_00D1);
    drv(1, L2, 0, Z, 1, 0, 0, '0);
    chkc("t1_out1", outstanding_o, 2'd1);
    chk1("t1_pend1", mpu_one_txn_pend_n_o, 1'b0);
    expect_resp(1'b0, 40'h00_0000_00D2);
    drv(0, Z, 0, Z, 1, 0, 0, '0);
    chkc("t1_out2", outstanding_o, 2'd2);
    drv(0, Z, 0, Z, 1, 0, 0, '0);
    chkc("t1_out3", outstanding_o, 2'd2);
    drv(0, Z, 0, Z, 1, 0, 1, 40'h00_0000_00D1);
    chkc("t1_out4", outstanding_o, 2'd2);
    chk1("t1_pend4", mpu_one_txn_pend_n_o, 1'b1);
    drv(0, Z, 0, Z, 1, 0, 1, 40'h00_0000_00D2);
    chkc("t1_out5", outstanding_o, 2'd1);
    chk1("t1_pend5", mpu_one_txn_pend_n_o, 1'b0);
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chkc("t1_out6", outstanding_o, 2'd0);

    // Grant lock: XIF stalled three cycles, LSU arrives in the second
    drv(0, Z, 1, X1, 0, 0, 0, '0);
    chkw("t2_trans0", mpu_trans_o, X1);
    chk1("t2_wait0", mpu_err_wait_o, 1'b0);
    chk1("t2_valid0", mpu_trans_valid_o, 1'b1);
    drv(1, L3, 1, X1, 0, 0, 0, '0);
    chkw("t2_trans1", mpu_trans_o, X1);
    chk1("t2_lsu_ready1", lsu_req_ready_o, 1'b0);
    drv(1, L3, 1, X1, 0, 0, 0, '0);
    chkw("t2_trans2", mpu_trans_o, X1);
    drv(1, L3, 1, X1, 1, 0, 0, '0);
    chkw("t2_trans3", mpu_trans_o, X1);
    chk1("t2_xif_ready3", xif_req_ready_o, 1'b1);
    chk1("t2_lsu_ready3", lsu_req_ready_o, 1'b0);
    expect_resp(1'b1, 40'h00_0000_00D3);
    drv(1, L3, 0, Z, 1, 0, 0, '0);
    chkw("t2_trans4", mpu_trans_o, L3);
    chk1("t2_lsu_ready4", lsu_req_ready_o, 1'b1);
    expect_resp(1'b0, 40'h00_0000_00D4);
    drv(0, Z, 0, Z, 0, 0, 1, 40'h00_0000_00D3);
    drv(0, Z, 0, Z, 0, 0, 1, 40'h00_0000_00D4);
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chkc("t2_out_end", outstanding_o, 2'd0);

    // XIF immediate MPU error: consumed without a FIFO entry
    drv(0, Z, 1, X2, 1, 1, 0, '0);
    chk1("t3_xif_ready", xif_req_ready_o, 1'b1);
    chk1("t3_wait", mpu_err_wait_o, 1'b0);
    chk1("t3_pend", mpu_one_txn_pend_n_o, 1'b0);
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chkc("t3_out", outstanding_o, 2'd0);

    // Full: both requesters blocked until a pop frees a slot
    drv(1, L1, 0, Z, 1, 0, 0, '0);
    expect_resp(1'b0, 40'h00_0000_00D5);
    drv(1, L2, 0, Z, 1, 0, 0, '0);
    expect_resp(1'b0, 40'h00_0000_00D6);
    drv(1, L3, 1, X1, 1, 0, 0, '0);
    chkc("t4_out_full", outstanding_o, 2'd2);
    chk1("t4_lsu_ready_full", lsu_req_ready_o, 1'b0);
    chk1("t4_xif_ready_full", xif_req_ready_o, 1'b0);
    chk1("t4_valid_full", mpu_trans_valid_o, 1'b0);
    drv(1, L3, 1, X1, 1, 0, 1, 40'h00_0000_00D5);
    chk1("t4_lsu_ready_pop", lsu_req_ready_o, 1'b0);
    chk1("t4_xif_ready_pop", xif_req_ready_o, 1'b0);
    g4 = RR;
    drv(1, L3, 1, X1, 1, 0, 0, '0);
    chkc("t4_out_after_pop", outstanding_o, 2'd1);
    chk1("t4_lsu_ready_acc", lsu_req_ready_o, ~g4);
    chk1("t4_xif_ready_acc", xif_req_ready_o, g4);
    chkw("t4_trans_acc", mpu_trans_o, g4 ? X1 : L3);
    expect_resp(g4, 40'h00_0000_00D7);
    drv(0, Z, 0, Z, 0, 0, 1, 40'h00_0000_00D6);
    chkc("t4_out_refill", outstanding_o, 2'd2);
    drv(0, Z, 0, Z, 0, 0, 1, 40'h00_0000_00D7);
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chkc("t4_out_end", outstanding_o, 2'd0);

    // Response with nothing outstanding
    drv(0, Z, 0, Z, 0, 0, 1, 40'h00_0000_00EE);
    chk1("t5_lsu_rv", lsu_resp_valid_o, 1'b0);
    chk1("t5_xif_rv", xif_resp_valid_o, 1'b0);
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chk1("t5_err_set", resp_err_o, 1'b1);
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chk1("t5_err_sticky", resp_err_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("t5_err_rst", resp_err_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Arbitration with both requesters valid; responses keep the count at one
    g6 = RR ? 4'b1010 : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      drv(1, L1, 1, X1, 1, 0, (i > 0), RESP_W'(32'hA0 + i - 1));
      chk1($sformatf("t6_wait%0d", i), mpu_err_wait_o, ~g6[i]);
      chk1($sformatf("t6_lsu_ready%0d", i), lsu_req_ready_o, ~g6[i]);
      chk1($sformatf("t6_xif_ready%0d", i), xif_req_ready_o, g6[i]);
      chk1($sformatf("t6_pend%0d", i), mpu_one_txn_pend_n_o, 1'b1);
      chkc($sformatf("t6_out%0d", i), outstanding_o, (i > 0) ? 2'd1 : 2'd0);
      expect_resp(g6[i], RESP_W'(32'hA0 + i));
    end
    drv(0, Z, 0, Z, 0, 0, 1, RESP_W'(32'hA3));
    chkc("t6_out_tail", outstanding_o, 2'd1);
    chk1("t6_pend_tail", mpu_one_txn_pend_n_o, 1'b0);
    drv(0, Z, 0, Z, 0, 0, 0, '0);
    chkc("t6_out_end", outstanding_o, 2'd0);

    repeat (3) @(negedge clk);
    chk1("scoreboard_drained", (exp_q.size() == 0), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
